// File: rtl/valrdy_pkg.sv
// Shared definitions for the valrdy queue library: pointer/count width
// helpers, default pointer/count types and the occupancy update encoding.
package valrdy_pkg;

  // Pointer width for a queue of the given depth; never narrower than 1 bit.
  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_PTR_W = ptr_width(DEFAULT_DEPTH);
  localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_DEPTH);

  typedef logic [DEFAULT_PTR_W-1:0] ptr_t;
  typedef logic [DEFAULT_CNT_W-1:0] cnt_t;

  // How the occupancy counter moves in a given cycle.
  typedef enum logic [1:0] {
    OCC_HOLD = 2'd0,
    OCC_INC  = 2'd1,
    OCC_DEC  = 2'd2
  } occ_op_e;

endpackage

// File: rtl/valrdy_regfile.sv
// DEPTH x BITWIDTH storage for valrdy queues: one synchronous write port,
// one combinational read port, synchronous clear of every entry on RESET.
module valrdy_regfile
  import valrdy_pkg::*;
#(
  parameter int BITWIDTH = 32,
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = ptr_width(DEPTH)
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                wen,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [BITWIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [BITWIDTH-1:0] rdata
);

  logic [BITWIDTH-1:0] mem_q [DEPTH];
  logic [BITWIDTH-1:0] mem_d [DEPTH];

  // Next storage contents: only the addressed entry changes on a write.
  always_comb begin
    mem_d = mem_q;
    if (wen) begin
      mem_d[waddr] = wdata;
    end
  end

  // Storage register with synchronous clear.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/valrdy_fifo.sv
// Parametrised valid/ready FIFO queue (BITWIDTH x DEPTH).
// recv_rdy depends only on internal occupancy, so send_rdy never reaches
// recv_rdy combinationally. Pointers wrap by explicit compare, so DEPTH need
// not be a power of two.
// Optional build macro VALRDY_FIFO_BYPASS_EN: when empty, a valid incoming
// message is presented on the send side in the same cycle and, if accepted,
// never touches storage.
module valrdy_fifo
  import valrdy_pkg::*;
#(
  parameter int BITWIDTH = 32,
  parameter int DEPTH    = 4
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       recv_val,
  output logic                       recv_rdy,
  input  logic [BITWIDTH-1:0]        recv_msg,
  output logic                       send_val,
  input  logic                       send_rdy,
  output logic [BITWIDTH-1:0]        send_msg,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic                empty;
  logic                full;
  logic                enq;
  logic                deq;
  logic                bypass_take;
  logic [BITWIDTH-1:0] head_msg;
  occ_op_e             occ_op;

  // Advance a pointer, wrapping after the last storage entry.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_FULL);
  assign recv_rdy = !full;
  assign count    = count_q;

`ifdef VALRDY_FIFO_BYPASS_EN
  // Empty queue: present the incoming message directly on the send side.
  always_comb begin
    send_val    = !empty;
    send_msg    = head_msg;
    bypass_take = 1'b0;
    if (empty && recv_val) begin
      send_val    = 1'b1;
      send_msg    = recv_msg;
      bypass_take = send_rdy;
    end
  end
`else
  // Send side is driven purely from stored state.
  always_comb begin
    send_val    = !empty;
    send_msg    = head_msg;
    bypass_take = 1'b0;
  end
`endif

  // Handshakes: a directly forwarded message is neither written nor popped.
  always_comb begin
    enq = recv_val && recv_rdy && !bypass_take;
    deq = send_val && send_rdy && !empty;
  end

  // Classify how occupancy changes this cycle.
  always_comb begin
    occ_op = OCC_HOLD;
    if (enq && !deq) begin
      occ_op = OCC_INC;
    end else if (deq && !enq) begin
      occ_op = OCC_DEC;
    end
  end

  // Next pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (deq) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case (occ_op)
      OCC_INC: count_d = count_q + CNT_W'(1);
      OCC_DEC: count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers; reset wins over any handshake.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  valrdy_regfile #(
    .BITWIDTH (BITWIDTH),
    .DEPTH    (DEPTH),
    .ADDR_W   (PTR_W)
  ) u_regfile (
    .CLK   (CLK),
    .RESET (RESET),
    .wen   (enq),
    .waddr (wr_ptr_q),
    .wdata (recv_msg),
    .raddr (rd_ptr_q),
    .rdata (head_msg)
  );

endmodule

// File: tb/tb_valrdy_fifo.sv
// Directed bench for valrdy_fifo: a DEPTH=4 instance for reset, fill/drain,
// streaming, mid-operation reset and empty-queue latency, plus a DEPTH=3
// instance for the full-while-draining case.
module tb_valrdy_fifo;

  logic        CLK;
  logic        RESET;

  logic        recv_val, recv_rdy, send_val, send_rdy;
  logic [31:0] recv_msg, send_msg;
  logic [2:0]  count;

  logic        d3_recv_val, d3_recv_rdy, d3_send_val, d3_send_rdy;
  logic [31:0] d3_recv_msg, d3_send_msg;
  logic [1:0]  d3_count;

  int total;
  int bad;

  valrdy_fifo #(.BITWIDTH(32), .DEPTH(4)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .recv_val (recv_val),
    .recv_rdy (recv_rdy),
    .recv_msg (recv_msg),
    .send_val (send_val),
    .send_rdy (send_rdy),
    .send_msg (send_msg),
    .count    (count)
  );

  valrdy_fifo #(.BITWIDTH(32), .DEPTH(3)) dut3 (
    .CLK      (CLK),
    .RESET    (RESET),
    .recv_val (d3_recv_val),
    .recv_rdy (d3_recv_rdy),
    .recv_msg (d3_recv_msg),
    .send_val (d3_send_val),
    .send_rdy (d3_send_rdy),
    .send_msg (d3_send_msg),
    .count    (d3_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    RESET = 1'b1;
    recv_val = 1'b0; recv_msg = '0; send_rdy = 1'b0;
    d3_recv_val = 1'b0; d3_recv_msg = '0; d3_send_rdy = 1'b0;

    // Reset then idle
    cyc();
    cyc();
    RESET = 1'b0;
    #1;
    chk("rst_recv_rdy", 32'(recv_rdy), 32'd1);
    chk("rst_send_val", 32'(send_val), 32'd0);
    chk("rst_send_msg", send_msg, 32'h0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst3_count", 32'(d3_count), 32'd0);
    cyc();

    // Fill with send_rdy low
    recv_val = 1'b1;
    for (int i = 0; i < 4; i++) begin
      recv_msg = 32'hA0 + 32'(i);
      #1;
      chk("fill_recv_rdy", 32'(recv_rdy), 32'd1);
      cyc();
      chk("fill_count", 32'(count), 32'(i + 1));
    end
    chk("full_recv_rdy", 32'(recv_rdy), 32'd0);
    chk("full_head", send_msg, 32'hA0);
    recv_msg = 32'hEE;
    cyc();
    chk("full_ignore_count", 32'(count), 32'd4);
    recv_val = 1'b0;

    // Drain in order
    send_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_val", 32'(send_val), 32'd1);
      chk("drain_msg", send_msg, 32'hA0 + 32'(i));
      cyc();
    end
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_send_val", 32'(send_val), 32'd0);
    send_rdy = 1'b0;

    // Streaming with two entries resident
    recv_val = 1'b1;
    recv_msg = 32'h0E; cyc();
    recv_msg = 32'h0F; cyc();
    chk("pre_stream_count", 32'(count), 32'd2);
    send_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      recv_msg = 32'h10 + 32'(i);
      #1;
      chk("stream_msg", send_msg, 32'h0E + 32'(i));
      cyc();
      chk("stream_count", 32'(count), 32'd2);
    end
    recv_val = 1'b0;
    #1;
    chk("stream_tail0", send_msg, 32'h14);
    cyc();
    chk("stream_tail1", send_msg, 32'h15);
    cyc();
    chk("stream_empty", 32'(count), 32'd0);
    send_rdy = 1'b0;

    // Mid-operation reset
    recv_val = 1'b1;
    for (int i = 0; i < 3; i++) begin
      recv_msg = 32'h31 + 32'(i);
      cyc();
    end
    chk("prereset_count", 32'(count), 32'd3);
    RESET = 1'b1; send_rdy = 1'b1; recv_msg = 32'h99;
    cyc();
    RESET = 1'b0; recv_val = 1'b0; send_rdy = 1'b0;
    #1;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_send_val", 32'(send_val), 32'd0);
    chk("midrst_send_msg", send_msg, 32'h0);
    chk("midrst_recv_rdy", 32'(recv_rdy), 32'd1);
    send_rdy = 1'b1;
    cyc();
    chk("midrst_idle_val", 32'(send_val), 32'd0);
    send_rdy = 1'b0;
    recv_val = 1'b1; recv_msg = 32'h77;
    cyc();
    recv_val = 1'b0;
    #1;
    chk("midrst_fresh_msg", send_msg, 32'h77);
    send_rdy = 1'b1;
    cyc();
    chk("midrst_fresh_gone", 32'(count), 32'd0);
    chk("midrst_no_stale", 32'(send_val), 32'd0);
    send_rdy = 1'b0;

    // Empty queue, producer and consumer both ready
    recv_val = 1'b1; recv_msg = 32'h5A; send_rdy = 1'b1;
    #1;
`ifdef VALRDY_FIFO_BYPASS_EN
    chk("byp_send_val", 32'(send_val), 32'd1);
    chk("byp_send_msg", send_msg, 32'h5A);
    cyc();
    recv_val = 1'b0; send_rdy = 1'b0;
    #1;
    chk("byp_count", 32'(count), 32'd0);
    chk("byp_after_val", 32'(send_val), 32'd0);
`else
    chk("nobyp_send_val", 32'(send_val), 32'd0);
    cyc();
    recv_val = 1'b0; send_rdy = 1'b0;
    #1;
    chk("nobyp_next_val", 32'(send_val), 32'd1);
    chk("nobyp_next_msg", send_msg, 32'h5A);
    chk("nobyp_next_count", 32'(count), 32'd1);
    send_rdy = 1'b1;
    cyc();
    send_rdy = 1'b0;
    chk("nobyp_drained", 32'(count), 32'd0);
`endif

    // DEPTH=3: full with consumer ready
    d3_recv_val = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d3_recv_msg = 32'hB0 + 32'(i);
      cyc();
    end
    chk("d3_full_count", 32'(d3_count), 32'd3);
    d3_recv_msg = 32'hB3; d3_send_rdy = 1'b1;
    #1;
    chk("d3_full_recv_rdy", 32'(d3_recv_rdy), 32'd0);
    chk("d3_full_head", d3_send_msg, 32'hB0);
    cyc();
    d3_recv_val = 1'b0;
    #1;
    chk("d3_after_count", 32'(d3_count), 32'd2);
    chk("d3_after_recv_rdy", 32'(d3_recv_rdy), 32'd1);
    chk("d3_after_head", d3_send_msg, 32'hB1);
    cyc();
    chk("d3_head2", d3_send_msg, 32'hB2);
    cyc();
    chk("d3_empty_count", 32'(d3_count), 32'd0);
    chk("d3_empty_val", 32'(d3_send_val), 32'd0);
    d3_send_rdy = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
